// File: rtl/jt49_divn.sv
// jt49_divn: CH-channel tone/period divider for the PSG core.
// Each channel counts cen edges up to a double-buffered period and then emits
// a one-clk tick, shaping its output as square, pulse, one-shot or off.
module jt49_divn #(
    parameter int W  = 12,
    parameter int CH = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cen,
    input  logic [CH*W-1:0]   period,
    input  logic [2*CH-1:0]   mode,
    input  logic [CH-1:0]     restart,
    output logic [CH-1:0]     out,
    output logic [CH-1:0]     tick
);

    typedef enum logic [1:0] {
        MD_SQUARE  = 2'b00,
        MD_PULSE   = 2'b01,
        MD_ONESHOT = 2'b10,
        MD_OFF     = 2'b11
    } mode_e;

    // LOAD: next cen edge copies the period into the shadow register.
    // RUN:  counting towards the terminal count.
    // HALT: one-shot has fired; frozen until restart or off.
    typedef enum logic [1:0] {
        ST_LOAD = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_e;

    localparam logic [W-1:0] ONE = W'(1);

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [W-1:0] period_i;
        mode_e        mode_i;
        logic [W-1:0] count_q, count_d;
        logic [W-1:0] cur_q, cur_d;
        logic [W-1:0] eff;
        state_e       st_q, st_d;
        logic         out_q, out_d;
        logic         tick_q, tick_d;

        assign period_i = period[i*W +: W];
        assign mode_i   = mode_e'(mode[2*i +: 2]);
        assign eff      = (cur_q == '0) ? ONE : cur_q;

        // Channel state register with asynchronous clear.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                count_q <= ONE;
                cur_q   <= '0;
                st_q    <= ST_LOAD;
                out_q   <= 1'b0;
                tick_q  <= 1'b0;
            end else begin
                count_q <= count_d;
                cur_q   <= cur_d;
                st_q    <= st_d;
                out_q   <= out_d;
                tick_q  <= tick_d;
            end
        end

        // Next-state: restart beats off, off beats any cen activity.
        always_comb begin
            count_d = count_q;
            cur_d   = cur_q;
            st_d    = st_q;
            out_d   = out_q;
            tick_d  = 1'b0;
            if (restart[i]) begin
                // Restart reloads directly, so counting resumes without a load edge.
                count_d = ONE;
                cur_d   = period_i;
                out_d   = 1'b0;
                st_d    = ST_RUN;
            end else if (mode_i == MD_OFF) begin
                count_d = ONE;
                out_d   = 1'b0;
                st_d    = ST_LOAD;
            end else if (cen) begin
                case (st_q)
                    ST_LOAD: begin
                        cur_d   = period_i;
                        count_d = ONE;
                        st_d    = ST_RUN;
                    end
                    ST_RUN: begin
                        if (count_q >= eff) begin
                            count_d = ONE;
                            cur_d   = period_i;
                            tick_d  = 1'b1;
                            case (mode_i)
                                MD_SQUARE:  out_d = ~out_q;
                                MD_PULSE:   out_d = 1'b1;
                                MD_ONESHOT: begin
                                    out_d = 1'b1;
                                    st_d  = ST_HALT;
                                end
                                default:    out_d = out_q;
                            endcase
                        end else begin
                            count_d = count_q + ONE;
                            if (mode_i == MD_PULSE) out_d = 1'b0;
                        end
                    end
                    default: begin
                        st_d = st_q;
                    end
                endcase
            end
        end

        assign out[i]  = out_q;
        assign tick[i] = tick_q;
    end

endmodule

// File: tb/tb_jt49_divn.sv
// tb_jt49_divn: directed checks of jt49_divn with hand-computed expectations.
module tb_jt49_divn;
    localparam int W  = 12;
    localparam int CH = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cen;
    logic [CH*W-1:0]   period;
    logic [2*CH-1:0]   mode;
    logic [CH-1:0]     restart;
    logic [CH-1:0]     out;
    logic [CH-1:0]     tick;

    int errors = 0;
    int checks = 0;

    // Values captured by slot(): out/tick at the cen edge, tick one clk later,
    // out at the end of the 4-clk slot.
    logic [CH-1:0] so, st, sa, se;
    logic [9:0]    o_tab, t_tab;

    jt49_divn #(.W(W), .CH(CH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cen     (cen),
        .period  (period),
        .mode    (mode),
        .restart (restart),
        .out     (out),
        .tick    (tick)
    );

    // 10 ns core clock.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input logic c);
        cen = c;
        @(posedge clk);
        #1;
    endtask

    // One cen interval of the 1-in-4 enable pattern.
    task automatic slot();
        cyc(1'b1);
        so = out;
        st = tick;
        cyc(1'b0);
        sa = tick;
        cyc(1'b0);
        cyc(1'b0);
        se = out;
    endtask

    task automatic do_restart(input int ch);
        restart[ch] = 1'b1;
        cyc(1'b0);
        restart[ch] = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        cen     = 1'b0;
        period  = '0;
        mode    = '1;
        restart = '0;
        cyc(1'b0);
        cyc(1'b0);
        chk("reset_out", 32'(out), 32'd0);
        chk("reset_tick", 32'(tick), 32'd0);

        // ch0 square, period 3
        mode[1:0]      = 2'b00;
        period[0 +: W] = 12'd3;
        rst_n = 1'b1;
        slot();
        chk("sq3_load_out", 32'(so[0]), 32'd0);
        chk("sq3_load_tick", 32'(st[0]), 32'd0);
        for (int k = 1; k <= 6; k++) begin
            slot();
            chk($sformatf("sq3_out_%0d", k), 32'(so[0]), 32'((k / 3) % 2));
            chk($sformatf("sq3_tick_%0d", k), 32'(st[0]), 32'(k % 3 == 0));
            if (k % 3 == 0) chk($sformatf("sq3_tickw_%0d", k), 32'(sa[0]), 32'd0);
        end

        // period 0 and 1 both toggle on every cen
        period[0 +: W] = 12'd0;
        do_restart(0);
        chk("p0_restart_out", 32'(out[0]), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            slot();
            chk($sformatf("p0_out_%0d", k), 32'(so[0]), 32'(k % 2));
            chk($sformatf("p0_tick_%0d", k), 32'(st[0]), 32'd1);
        end
        period[0 +: W] = 12'd1;
        do_restart(0);
        for (int k = 1; k <= 2; k++) begin
            slot();
            chk($sformatf("p1_out_%0d", k), 32'(so[0]), 32'(k % 2));
            chk($sformatf("p1_tick_%0d", k), 32'(st[0]), 32'd1);
        end

        // ch1 square period 5, rewritten to 2 mid-interval
        mode           = 6'b11_00_11;
        period[W +: W] = 12'd5;
        slot();
        chk("ch1_load_out", 32'(so[1]), 32'd0);
        slot();
        chk("ch1_out_1", 32'(so[1]), 32'd0);
        period[W +: W] = 12'd2;
        o_tab = 10'h260;
        t_tab = 10'h2A0;
        for (int k = 2; k <= 9; k++) begin
            slot();
            chk($sformatf("ch1_out_%0d", k), 32'(so[1]), 32'(o_tab[k]));
            chk($sformatf("ch1_tick_%0d", k), 32'(st[1]), 32'(t_tab[k]));
        end

        // ch2 pulse period 4
        mode             = 6'b01_11_11;
        period[2*W +: W] = 12'd4;
        slot();
        chk("pl_load_out", 32'(so[2]), 32'd0);
        for (int k = 1; k <= 8; k++) begin
            slot();
            chk($sformatf("pl_out_%0d", k), 32'(so[2]), 32'(k % 4 == 0));
            chk($sformatf("pl_hold_%0d", k), 32'(se[2]), 32'(k % 4 == 0));
            chk($sformatf("pl_tick_%0d", k), 32'(st[2]), 32'(k % 4 == 0));
        end
        for (int j = 1; j <= 8; j++) begin
            cyc(1'b1);
            chk($sformatf("plc_out_%0d", j), 32'(out[2]), 32'(j % 4 == 0));
            chk($sformatf("plc_tick_%0d", j), 32'(tick[2]), 32'(j % 4 == 0));
        end
        cen = 1'b0;

        // ch0 one-shot period 6
        mode           = 6'b11_11_10;
        period[0 +: W] = 12'd6;
        slot();
        chk("os_load_out", 32'(so[0]), 32'd0);
        for (int k = 1; k <= 9; k++) begin
            slot();
            chk($sformatf("os_out_%0d", k), 32'(so[0]), 32'(k >= 6));
            chk($sformatf("os_tick_%0d", k), 32'(st[0]), 32'(k == 6));
        end
        do_restart(0);
        chk("os_restart_out", 32'(out[0]), 32'd0);
        for (int k = 1; k <= 6; k++) begin
            slot();
            chk($sformatf("os2_out_%0d", k), 32'(so[0]), 32'(k == 6));
            chk($sformatf("os2_tick_%0d", k), 32'(st[0]), 32'(k == 6));
        end

        // restart coinciding with a terminal count
        mode[1:0]      = 2'b00;
        period[0 +: W] = 12'd2;
        do_restart(0);
        cyc(1'b1);
        cyc(1'b1);
        chk("rt_e2_out", 32'(out[0]), 32'd1);
        chk("rt_e2_tick", 32'(tick[0]), 32'd1);
        cyc(1'b1);
        restart[0] = 1'b1;
        cyc(1'b1);
        restart[0] = 1'b0;
        chk("rt_hit_out", 32'(out[0]), 32'd0);
        chk("rt_hit_tick", 32'(tick[0]), 32'd0);
        cyc(1'b1);
        chk("rt_e5_out", 32'(out[0]), 32'd0);
        chk("rt_e5_tick", 32'(tick[0]), 32'd0);
        cyc(1'b1);
        chk("rt_e6_out", 32'(out[0]), 32'd1);
        chk("rt_e6_tick", 32'(tick[0]), 32'd1);

        // off mode, then a load edge on re-enable
        mode[1:0] = 2'b11;
        cyc(1'b1);
        chk("off_out", 32'(out[0]), 32'd0);
        chk("off_tick", 32'(tick[0]), 32'd0);
        mode[1:0] = 2'b00;
        cyc(1'b1);
        chk("off_load_out", 32'(out[0]), 32'd0);
        chk("off_load_tick", 32'(tick[0]), 32'd0);
        cyc(1'b1);
        chk("off_e1_out", 32'(out[0]), 32'd0);
        cyc(1'b1);
        chk("off_e2_out", 32'(out[0]), 32'd1);
        chk("off_e2_tick", 32'(tick[0]), 32'd1);

        // asynchronous reset while out=1 and tick=1
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out", 32'(out[0]), 32'd0);
        chk("arst_tick", 32'(tick[0]), 32'd0);
        cyc(1'b1);
        rst_n = 1'b1;
        cyc(1'b1);
        chk("rel_load_out", 32'(out[0]), 32'd0);
        chk("rel_load_tick", 32'(tick[0]), 32'd0);
        cyc(1'b1);
        chk("rel_e1_out", 32'(out[0]), 32'd0);
        cyc(1'b1);
        chk("rel_e2_out", 32'(out[0]), 32'd1);
        chk("rel_e2_tick", 32'(tick[0]), 32'd1);
        cen = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
